// File: rtl/tt_dpll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_dpll_lock_ctrl
// Brief    : DPLL lock-acquisition sequencer; steps loop gain coarse->fine,
//            declares lock and restarts acquisition on lock loss or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tt_dpll_lock_ctrl #(
    parameter int LOCK_WIN   = 16,
    parameter int LOCK_TOL   = 2,
    parameter int UNLOCK_TOL = 4,
    parameter int LOCK_WINS  = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic       i_clk_ref,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_up,
    input  logic       i_down,
    output logic [1:0] o_gain_sel,
    output logic       o_hold,
    output logic       o_locked,
    output logic       o_timeout,
    output logic [2:0] o_state,
    output logic [3:0] o_relock_cnt
);

    localparam int CW = $clog2(LOCK_WIN + 1);
    localparam int SW = $clog2(LOCK_WINS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Tolerances are clamped to the window length so they fit the count width.
    localparam int c_lock_tol_i   = (LOCK_TOL > LOCK_WIN) ? LOCK_WIN : LOCK_TOL;
    localparam int c_unlock_tol_i = (UNLOCK_TOL > LOCK_WIN) ? LOCK_WIN : UNLOCK_TOL;

    localparam logic [CW-1:0] c_win_last    = CW'(LOCK_WIN - 1);
    localparam logic [CW-1:0] c_lock_tol    = CW'(c_lock_tol_i);
    localparam logic [CW-1:0] c_unlock_tol  = CW'(c_unlock_tol_i);
    localparam logic [SW-1:0] c_streak_last = SW'(LOCK_WINS - 1);
    localparam logic [TW-1:0] c_tmo_last    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COARSE = 3'd1,
        S_MEDIUM = 3'd2,
        S_FINE   = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_win_cnt;
    logic [CW-1:0]   r_up_cnt;
    logic [CW-1:0]   r_dn_cnt;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_tmo_cnt;
    logic [1:0]      r_noisy;
    logic            r_timeout;
    logic [3:0]      r_relock_cnt;

    logic [CW-1:0]   w_up_tot;
    logic [CW-1:0]   w_dn_tot;
    logic [CW-1:0]   w_diff;
    logic            w_win_end;
    logic            w_quiet;
    logic            w_noisy_win;
    logic            w_advance;
    logic            w_tmo_hit;
    logic            w_unlock;
    logic            w_tmo_pulse;
    logic            w_relock_inc;
    logic            w_clear;

    // Window-end totals include the current cycle's detector pulses.
    assign w_up_tot    = r_up_cnt + {{(CW-1){1'b0}}, i_up};
    assign w_dn_tot    = r_dn_cnt + {{(CW-1){1'b0}}, i_down};
    assign w_diff      = (w_up_tot >= w_dn_tot) ? (w_up_tot - w_dn_tot)
                                                : (w_dn_tot - w_up_tot);
    assign w_win_end   = (r_win_cnt == c_win_last);
    assign w_quiet     = (w_diff <= c_lock_tol);
    assign w_noisy_win = (w_diff > c_unlock_tol);
    assign w_advance   = w_quiet && (r_streak == c_streak_last);
    assign w_tmo_hit   = (r_tmo_cnt == c_tmo_last);
    assign w_unlock    = w_noisy_win && (r_noisy == 2'd1);

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tmo_pulse  = 1'b0;
        w_relock_inc = 1'b0;
        if (!i_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_COARSE;
                S_COARSE, S_MEDIUM, S_FINE: begin
                    if (w_win_end) begin
                        // An advance on the same window end beats a timeout.
                        if (w_advance) begin
                            if (r_state == S_COARSE)      w_state_nxt = S_MEDIUM;
                            else if (r_state == S_MEDIUM) w_state_nxt = S_FINE;
                            else                          w_state_nxt = S_LOCKED;
                        end else if (w_tmo_hit) begin
                            w_tmo_pulse = 1'b1;
                            w_state_nxt = S_COARSE;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_win_end && w_unlock) begin
                        w_state_nxt  = S_COARSE;
                        w_relock_inc = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A COARSE timeout keeps the state but restarts everything like a change.
    assign w_clear = !i_enable || (w_state_nxt != r_state) || w_tmo_pulse;

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            r_win_cnt <= '0;
            r_up_cnt  <= '0;
            r_dn_cnt  <= '0;
            r_streak  <= '0;
            r_tmo_cnt <= '0;
            r_noisy   <= 2'd0;
        end else if (w_clear) begin
            r_win_cnt <= '0;
            r_up_cnt  <= '0;
            r_dn_cnt  <= '0;
            r_streak  <= '0;
            r_tmo_cnt <= '0;
            r_noisy   <= 2'd0;
        end else if (w_win_end) begin
            r_win_cnt <= '0;
            r_up_cnt  <= '0;
            r_dn_cnt  <= '0;
            if (r_state == S_LOCKED) begin
                r_noisy <= w_noisy_win ? (r_noisy + 2'd1) : 2'd0;
            end else begin
                r_streak  <= w_quiet ? (r_streak + SW'(1)) : '0;
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end else begin
            r_win_cnt <= r_win_cnt + CW'(1);
            r_up_cnt  <= w_up_tot;
            r_dn_cnt  <= w_dn_tot;
        end
    end

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            r_timeout    <= 1'b0;
            r_relock_cnt <= 4'd0;
        end else begin
            r_timeout <= w_tmo_pulse;
            if (w_relock_inc && (r_relock_cnt != 4'hF)) begin
                r_relock_cnt <= r_relock_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        o_gain_sel = 2'd0;
        o_hold     = 1'b0;
        o_locked   = 1'b0;
        case (r_state)
            S_IDLE:   o_hold     = 1'b1;
            S_MEDIUM: o_gain_sel = 2'd1;
            S_FINE:   o_gain_sel = 2'd2;
            S_LOCKED: begin
                o_gain_sel = 2'd2;
                o_locked   = 1'b1;
            end
            default:  o_gain_sel = 2'd0;
        endcase
    end

    assign o_state      = r_state;
    assign o_timeout    = r_timeout;
    assign o_relock_cnt = r_relock_cnt;

endmodule
`default_nettype wire
